// File: rtl/eth_tx_arb_pkg.sv
// ----------------------------------------------------------------------------
// eth_tx_arb_pkg
// Shared definitions for the Ethernet TX AXI-Stream arbiter:
//   - arb_state_t   : arbiter FSM state encoding (IDLE / PASS / DROP)
//   - MAX_PORTS     : widest requester vector the select helpers handle
//   - PTR_W         : width of a port index / last-grant pointer
//   - rr_pick       : round-robin priority pick (request + last pointer)
//   - onehot_to_ptr : one-hot grant vector to port index
// ----------------------------------------------------------------------------
package eth_tx_arb_pkg;

    localparam int MAX_PORTS = 4;
    localparam int PTR_W     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } arb_state_t;

    // Searches the ports in the order last+1, last+2, ... (modulo ports) and
    // returns a one-hot vector for the first one requesting, or zero.
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input logic [PTR_W-1:0]     last,
        input int                   ports
    );
        logic [MAX_PORTS-1:0] pick;
        logic [PTR_W-1:0]     idx;
        logic                 found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_PORTS; k++) begin
            if (k <= ports) begin
                idx = PTR_W'((int'(last) + k) % ports);
                if (!found && req[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] onehot_to_ptr(input logic [MAX_PORTS-1:0] oh);
        logic [PTR_W-1:0] ptr;
        ptr = '0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (oh[k]) ptr = PTR_W'(k);
        end
        return ptr;
    endfunction

endpackage

// File: rtl/eth_rr_select.sv
// ----------------------------------------------------------------------------
// eth_rr_select
// Combinational round-robin priority selector.
// Ports:
//   req   [PORTS-1:0] : request vector, one bit per requester
//   last  [PTR_W-1:0] : index of the most recently served requester
//   grant [PORTS-1:0] : one-hot winner (zero when nothing requests)
// ----------------------------------------------------------------------------
module eth_rr_select
    import eth_tx_arb_pkg::*;
#(
    parameter int PORTS = 2
) (
    input  logic [PORTS-1:0] req,
    input  logic [PTR_W-1:0] last,
    output logic [PORTS-1:0] grant
);

    logic [MAX_PORTS-1:0] pick;
    logic                 unused_pick;

    assign pick  = rr_pick(MAX_PORTS'(req), last, PORTS);
    assign grant = pick[PORTS-1:0];

    // Bits above PORTS are always zero; fold them so nothing dangles.
    assign unused_pick = ^pick;

endmodule

// File: rtl/eth_tx_axis_arb_64.sv
// ----------------------------------------------------------------------------
// eth_tx_axis_arb_64
// Frame-level round-robin arbiter merging PORTS AXI-Stream sources into the
// single AXI-Stream input of a MAC transmitter. A grant is held for a whole
// frame; frames longer than MAX_BEATS are cut (last forwarded beat carries
// tlast=1, tuser[0]=1) and the remainder is drained and discarded.
// Ports:
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   s_axis_*              : requester streams, requester i in slice i
//   m_axis_*              : merged stream towards the MAC (one register stage)
//   cfg_enable            : permits new grants; an owned frame always completes
//   grant                 : one-hot current owner (zero while idle)
//   busy                  : a frame is owned or an output beat is pending
//   trunc_error           : one-cycle pulse alongside a truncated last beat
// ----------------------------------------------------------------------------
module eth_tx_axis_arb_64
    import eth_tx_arb_pkg::*;
#(
    parameter int PORTS      = 2,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int MAX_BEATS  = 1200
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    output logic [PORTS-1:0]            s_axis_tready,
    input  logic [PORTS-1:0]            s_axis_tlast,
    input  logic [PORTS*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [USER_WIDTH-1:0]       m_axis_tuser,
    input  logic                        cfg_enable,
    output logic [PORTS-1:0]            grant,
    output logic                        busy,
    output logic                        trunc_error
);

    arb_state_t            state, state_nxt;
    logic [PTR_W-1:0]      last_grant;
    logic [15:0]           beat_cnt;
    logic [PORTS-1:0]      rr_grant;

    logic                  out_ready;
    logic                  take_grant;
    logic                  accept;
    logic                  frame_end;
    logic                  trunc_hit;

    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic [USER_WIDTH-1:0] sel_user;

    eth_rr_select #(
        .PORTS (PORTS)
    ) u_rr_select (
        .req   (s_axis_tvalid),
        .last  (last_grant),
        .grant (rr_grant)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign out_ready = !m_axis_tvalid || m_axis_tready;

    // Owner's handshake and payload, steered by the one-hot grant.
    assign sel_valid = |(s_axis_tvalid & grant);
    assign sel_last  = |(s_axis_tlast & grant);

    always_comb begin
        sel_data = '0;
        sel_keep = '0;
        sel_user = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant[i]) begin
                sel_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                sel_user = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------------
    // FSM: next state and handshake decode
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can
        // leave one unassigned and infer a latch.
        state_nxt     = state;
        s_axis_tready = '0;
        take_grant    = 1'b0;
        accept        = 1'b0;
        frame_end     = 1'b0;
        trunc_hit     = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_enable && |s_axis_tvalid) begin
                    take_grant = 1'b1;
                    state_nxt  = PASS;
                end
            end
            PASS: begin
                s_axis_tready = grant & {PORTS{out_ready}};
                if (sel_valid && out_ready) begin
                    accept = 1'b1;
                    if (sel_last) begin
                        frame_end = 1'b1;
                        state_nxt = IDLE;
                    end else if (beat_cnt == 16'(MAX_BEATS - 1)) begin
                        // This beat is number MAX_BEATS: close the frame here.
                        trunc_hit = 1'b1;
                        state_nxt = DROP;
                    end
                end
            end
            DROP: begin
                // Sink the rest of the oversize frame without touching m_axis.
                s_axis_tready = grant;
                if (sel_valid && sel_last) begin
                    frame_end = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Grant ownership, round-robin pointer, beat counter, truncation pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant       <= '0;
            last_grant  <= PTR_W'(PORTS - 1);
            beat_cnt    <= '0;
            trunc_error <= 1'b0;
        end else begin
            trunc_error <= trunc_hit;
            if (take_grant) begin
                grant    <= rr_grant;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
            if (frame_end) begin
                grant      <= '0;
                last_grant <= onehot_to_ptr(MAX_PORTS'(grant));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            m_axis_tkeep  <= sel_keep;
            m_axis_tlast  <= sel_last | trunc_hit;
            m_axis_tuser  <= sel_user | USER_WIDTH'(trunc_hit);
        end else if (m_axis_tready) begin
            // Payload is left as-is; only valid drops once the beat is taken.
            m_axis_tvalid <= 1'b0;
        end
    end

    assign busy = (state != IDLE) || m_axis_tvalid;

endmodule

// File: doc/eth_tx_axis_arb_64.md
ETH_TX_AXIS_ARB_64 -- requirements
Module: eth_tx_axis_arb_64

Interface
REQ-001 SHALL have parameter PORTS, default 2, number of AXI-Stream requesters (legal 2..4).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, beat width; KEEP_WIDTH default DATA_WIDTH/8; USER_WIDTH default 1.
REQ-003 SHALL have parameter MAX_BEATS, default 1200, maximum beats per frame before truncation (legal 8..65535).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk input 1 (all logic rising-edge), then rst input 1 (asynchronous, active-high).
REQ-005 Port s_axis_tdata input PORTS*DATA_WIDTH; requester i in slice i.
REQ-006 Ports s_axis_tkeep input PORTS*KEEP_WIDTH; s_axis_tvalid, s_axis_tready (output), s_axis_tlast input/output PORTS; s_axis_tuser input PORTS*USER_WIDTH.
REQ-007 Ports m_axis_tdata output DATA_WIDTH; m_axis_tkeep output KEEP_WIDTH; m_axis_tvalid output 1; m_axis_tready input 1; m_axis_tlast output 1; m_axis_tuser output USER_WIDTH; feeds MAC TX AXI input.
REQ-008 Port cfg_enable input 1: permits new grants.
REQ-009 Port grant output PORTS (one-hot, current owner); busy output 1; trunc_error output 1 (one-cycle pulse).

Function
REQ-010 States SHALL be IDLE, PASS, DROP.
REQ-011 In IDLE with cfg_enable=1 and any s_axis_tvalid=1, SHALL register grant to the first requesting port after last_grant in round-robin order, go PASS next cycle; no s_axis_tready asserted in IDLE.
REQ-012 last_grant SHALL reset to PORTS-1 so port 0 wins first arbitration.
REQ-013 Output SHALL be a single register stage: s_axis_tready[g] = (state==PASS) && (!m_axis_tvalid || m_axis_tready); all other tready=0.
REQ-014 Accepted beat SHALL appear on m_axis one cycle after acceptance, data/keep/user unchanged; m_axis_tvalid held with stable payload until m_axis_tready.
REQ-015 Full throughput SHALL be sustained in PASS while m_axis_tready=1 and source valid; one IDLE cycle minimum between frames.
REQ-016 Granted source deasserting tvalid mid-frame SHALL NOT change grant; m_axis_tvalid drops (underflow handled by MAC).
REQ-017 16-bit beat counter SHALL clear on grant, increment per accepted beat.
REQ-018 On accepted beat with tlast=1 in PASS: go IDLE, last_grant<=grant, grant cleared.
REQ-019 On accepted beat number MAX_BEATS with tlast=0: forward it with m_axis_tlast=1, m_axis_tuser[0]=1, pulse trunc_error, go DROP.
REQ-020 In DROP, s_axis_tready[g]=1 unconditionally, beats discarded, m_axis untouched; on tlast go IDLE, update last_grant.
REQ-021 cfg_enable=0 SHALL block only new grants; frame in PASS/DROP completes.
REQ-022 Requester raising tvalid while another is granted SHALL wait; no starvation: each waiting port served within PORTS-1 frames.
REQ-023 busy SHALL be 1 when state!=IDLE or m_axis_tvalid=1.

Reset
REQ-024 rst asserted (any time, including mid-frame) SHALL force: state IDLE, grant 0, last_grant PORTS-1, counter 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata/tkeep/tuser 0, all s_axis_tready 0, trunc_error 0, busy 0.
REQ-025 After rst release, first grant SHALL occur no earlier than first rising edge with rst=0.

Structure
REQ-026 State encoding and round-robin select function SHALL live in shared package eth_tx_arb_pkg.
REQ-027 Round-robin priority selector SHALL be sub-module eth_rr_select (request, last pointer -> one-hot grant, combinational).

Verification
REQ-028 Port0 and port1 each hold a 3-beat frame at reset release, m_axis_tready=1 -> output port0 frame then port1 frame, one IDLE gap, grant 01 then 10.
REQ-029 Port1 continuous frames, port0 raises tvalid mid-frame -> after port1 tlast, port0 granted next.
REQ-030 MAX_BEATS=8, port0 sends 12-beat frame -> 8 beats out, beat 8 tlast=1 tuser=1, trunc_error one pulse, 4 beats dropped with tready=1, no output.
REQ-031 m_axis_tready toggled 1/0 each cycle during 6-beat frame -> 6 beats in order, payload stable while stalled, no loss/duplication.
REQ-032 rst asserted at beat 3 of 6-beat frame -> next cycle all outputs zero; after release port0 re-arbitrated fresh.
REQ-033 cfg_enable=0 during PASS -> current frame completes, no new grant until cfg_enable=1.
